// File: rtl/io_vector_checker.sv
// Self-test sequencer: applies exhaustive or LFSR stimulus vectors to a DUT,
// waits for them to settle, compares the response against a golden model and
// keeps a saturating fail count and the index of the first failing vector.
module io_vector_checker #(
  parameter int unsigned NUM_IN        = 2,
  parameter int unsigned NUM_OUT       = 1,
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               global_resetn,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [15:0]        seed,
  input  logic [CNT_W-1:0]   vec_count,
  output logic [NUM_IN-1:0]  dut_in,
  input  logic [NUM_OUT-1:0] dut_out,
  input  logic [NUM_OUT-1:0] exp_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   fail_count,
  output logic [CNT_W-1:0]   first_fail_idx,
  output logic [CNT_W-1:0]   vec_idx
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned SC_W   = 8;
  localparam logic [LFSR_W-1:0] LFSR_INIT = 16'hACE1;
  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [SC_W-1:0]   SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t              state_q, state_d;
  logic [SC_W-1:0]     settle_q, settle_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                mode_q, mode_d;
  logic [CNT_W-1:0]    vcnt_q, vcnt_d;
  logic [NUM_IN-1:0]   dut_in_d;
  logic                busy_d, done_d, pass_d;
  logic [CNT_W-1:0]    fail_d, ffi_d, vidx_d;

  logic [LFSR_W-1:0]   lfsr_step;
  logic [LFSR_W-1:0]   seed_eff;
  logic                last_vec;
  logic                mismatch;

  // Datapath helpers: next LFSR value, effective seed, end-of-run and compare
  always_comb begin
    lfsr_step = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    seed_eff  = (seed == '0) ? LFSR_INIT : seed;
    last_vec  = mode_q ? (vec_idx == (vcnt_q - CNT_W'(1))) : (dut_in == '1);
    mismatch  = (dut_out != exp_out);
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    lfsr_d   = lfsr_q;
    mode_d   = mode_q;
    vcnt_d   = vcnt_q;
    dut_in_d = dut_in;
    fail_d   = fail_count;
    ffi_d    = first_fail_idx;
    vidx_d   = vec_idx;

    case (state_q)
      IDLE, DONE: begin
        // abort masks a simultaneous start
        if (start && !abort) begin
          fail_d   = '0;
          vidx_d   = '0;
          ffi_d    = '1;
          settle_d = '0;
          mode_d   = mode;
          vcnt_d   = vec_count;
          if (mode) begin
            lfsr_d   = seed_eff;
            dut_in_d = seed_eff[NUM_IN-1:0];
            state_d  = (vec_count == '0) ? DONE : SETTLE;
          end else begin
            dut_in_d = '0;
            state_d  = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = CHECK;
        end else begin
          settle_d = settle_q + SC_W'(1);
        end
      end
      CHECK: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (mismatch) begin
            if (fail_count != '1) fail_d = fail_count + CNT_W'(1);
            if (first_fail_idx == '1) ffi_d = vec_idx;
          end
          if (last_vec) begin
            state_d = DONE;
          end else begin
            vidx_d   = vec_idx + CNT_W'(1);
            settle_d = '0;
            state_d  = SETTLE;
            if (mode_q) begin
              lfsr_d   = lfsr_step;
              dut_in_d = lfsr_step[NUM_IN-1:0];
            end else begin
              dut_in_d = dut_in + NUM_IN'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (fail_d == '0);
  end

  // State and output registers
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      lfsr_q         <= LFSR_INIT;
      mode_q         <= 1'b0;
      vcnt_q         <= '0;
      dut_in         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_idx <= '1;
      vec_idx        <= '0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      lfsr_q         <= lfsr_d;
      mode_q         <= mode_d;
      vcnt_q         <= vcnt_d;
      dut_in         <= dut_in_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      fail_count     <= fail_d;
      first_fail_idx <= ffi_d;
      vec_idx        <= vidx_d;
    end
  end

endmodule

// File: tb/tb_io_vector_checker.sv
// Bench for io_vector_checker: a default-parameter instance (AND golden,
// AND/OR DUT) and a narrow-counter instance (3 inputs, 2-bit counters,
// stuck-at-1 DUT). Expected vectors are queued at start and popped as applied.
module tb_io_vector_checker;

  localparam int unsigned S = 5;
  localparam int unsigned PV = S + 1;

  logic clk;
  logic rst_n;

  // instance 0: default parameters
  logic        start0, abort0, mode0, use_or;
  logic [15:0] seed0, vc0;
  logic [1:0]  di0;
  logic [0:0]  do0, eo0;
  logic        busy0, done0, pass0;
  logic [15:0] fc0, ffi0, vi0;

  // instance 1: NUM_IN=3, CNT_W=2
  logic        start1, abort1, mode1;
  logic [15:0] seed1;
  logic [1:0]  vc1;
  logic [2:0]  di1;
  logic [0:0]  do1, eo1;
  logic        busy1, done1, pass1;
  logic [1:0]  fc1, ffi1, vi1;

  int n_tests;
  int n_fail;
  logic [15:0] q0[$];
  logic [15:0] q1[$];

  assign eo0 = &di0;
  assign do0 = use_or ? |di0 : &di0;
  assign eo1 = &di1;
  assign do1 = 1'b1;

  io_vector_checker u0 (
    .clk(clk), .global_resetn(rst_n), .start(start0), .abort(abort0),
    .mode(mode0), .seed(seed0), .vec_count(vc0), .dut_in(di0),
    .dut_out(do0), .exp_out(eo0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_count(fc0), .first_fail_idx(ffi0), .vec_idx(vi0)
  );

  io_vector_checker #(.NUM_IN(3), .NUM_OUT(1), .SETTLE_CYCLES(S), .CNT_W(2)) u1 (
    .clk(clk), .global_resetn(rst_n), .start(start1), .abort(abort1),
    .mode(mode1), .seed(seed1), .vec_count(vc1), .dut_in(di1),
    .dut_out(do1), .exp_out(eo1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fc1), .first_fail_idx(ffi1), .vec_idx(vi1)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // One full run on instance 0; expected vectors and result come from the model
  task automatic run0(input logic m, input logic [15:0] sd, input int nv, input logic use_or_i);
    logic [15:0] lf;
    logic [1:0]  v;
    int n, k, got, efail, effi;
    use_or = use_or_i;
    n = m ? nv : 4;
    lf = (sd == 16'h0) ? 16'hACE1 : sd;
    efail = 0;
    effi = 32'hFFFF;
    for (int i = 0; i < n; i++) begin
      v = m ? lf[1:0] : 2'(i);
      q0.push_back({14'b0, v});
      if (use_or_i && (^v)) begin
        if (efail == 0) effi = i;
        efail++;
      end
      if (m) lf = lfsr_ref(lf);
    end
    @(negedge clk);
    mode0 = m; seed0 = sd; vc0 = 16'(nv); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    got = -1;
    k = 0;
    for (int c = 0; c <= int'(PV) * n + 10; c++) begin
      if (done0) begin
        got = c;
        break;
      end
      check_val("r0_busy", 32'(busy0), 1);
      if ((c % int'(PV)) == 0 && q0.size() > 0) begin
        check_val("r0_dut_in", 32'(di0), 32'(q0.pop_front()));
        check_val("r0_vec_idx", 32'(vi0), k);
        k++;
      end
      @(posedge clk); #1;
    end
    check_val("r0_done_latency", got, int'(PV) * n);
    check_val("r0_sb_empty", q0.size(), 0);
    check_val("r0_fail_count", 32'(fc0), efail);
    check_val("r0_first_fail", 32'(ffi0), effi);
    check_val("r0_pass", 32'(pass0), (efail == 0) ? 1 : 0);
    check_val("r0_busy_done", 32'(busy0), 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("r0_hold_done", 32'(done0), 1);
    check_val("r0_hold_fail", 32'(fc0), efail);
    check_val("r0_hold_pass", 32'(pass0), (efail == 0) ? 1 : 0);
  endtask

  // Exhaustive run on instance 1 (stuck-at-1 DUT); optional abort at cycle abort_at
  task automatic run1(input int abort_at);
    int n, k, got;
    n = (abort_at >= 0) ? 2 : 8;
    for (int i = 0; i < n; i++) q1.push_back(16'(i));
    @(negedge clk);
    mode1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    got = -1;
    k = 0;
    for (int c = 0; c <= int'(PV) * 8 + 10; c++) begin
      if (done1) begin
        got = c;
        break;
      end
      if ((c % int'(PV)) == 0 && q1.size() > 0) begin
        check_val("r1_dut_in", 32'(di1), 32'(q1.pop_front()));
        check_val("r1_vec_idx", 32'(vi1), k % 4);
        k++;
      end
      if (c == 3) start1 = 1'b1;
      if (c == 4) start1 = 1'b0;
      if (c == abort_at) begin
        abort1 = 1'b1;
        @(posedge clk); #1 abort1 = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    check_val("r1_sb_empty", q1.size(), 0);
    if (abort_at < 0) begin
      check_val("r1_done_latency", got, int'(PV) * 8);
      check_val("r1_fail_sat", 32'(fc1), 3);
      check_val("r1_first_fail", 32'(ffi1), 0);
      check_val("r1_pass", 32'(pass1), 0);
    end else begin
      check_val("r1_abort_busy", 32'(busy1), 0);
      check_val("r1_abort_done", 32'(done1), 0);
      check_val("r1_abort_idx", 32'(vi1), 1);
      check_val("r1_abort_fail", 32'(fc1), 1);
      check_val("r1_abort_ffi", 32'(ffi1), 0);
      check_val("r1_abort_dut_in", 32'(di1), 1);
      repeat (3) @(posedge clk);
      #1;
      check_val("r1_idle_busy", 32'(busy1), 0);
      check_val("r1_idle_idx", 32'(vi1), 1);
      @(negedge clk);
      start1 = 1'b1; abort1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0; abort1 = 1'b0;
      check_val("r1_abort_wins_busy", 32'(busy1), 0);
      check_val("r1_abort_wins_idx", 32'(vi1), 1);
    end
  endtask

  initial begin
    int i;
    n_tests = 0; n_fail = 0;
    clk = 1'b0; rst_n = 1'b0;
    start0 = 0; abort0 = 0; mode0 = 0; use_or = 0; seed0 = '0; vc0 = '0;
    start1 = 0; abort1 = 0; mode1 = 0; seed1 = '0; vc1 = '0;
    #22;
    check_val("rst_dut_in", 32'(di0), 0);
    check_val("rst_ffi", 32'(ffi0), 32'hFFFF);
    check_val("rst_ffi1", 32'(ffi1), 3);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("idle_busy", 32'(busy0), 0);
    check_val("idle_done", 32'(done0), 0);

    run0(1'b0, 16'h0, 0, 1'b0);     // exhaustive, AND vs AND
    run0(1'b0, 16'h0, 0, 1'b1);     // exhaustive, OR vs AND
    run0(1'b1, 16'h0, 7, 1'b0);     // random, seed 0 -> ACE1
    run0(1'b1, 16'h1234, 0, 1'b0);  // random, zero vectors
    run0(1'b1, 16'h1234, 9, 1'b1);  // random, OR vs AND

    // reset in the middle of a run
    @(negedge clk);
    use_or = 1'b1; mode0 = 1'b0; start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    i = 0;
    while (vi0 != 16'd2 && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    check_val("rst_reach_idx2", 32'(vi0), 2);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_dut_in", 32'(di0), 0);
    check_val("midrst_busy", 32'(busy0), 0);
    check_val("midrst_done", 32'(done0), 0);
    check_val("midrst_pass", 32'(pass0), 0);
    check_val("midrst_fail", 32'(fc0), 0);
    check_val("midrst_idx", 32'(vi0), 0);
    check_val("midrst_ffi", 32'(ffi0), 32'hFFFF);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("postrst_busy", 32'(busy0), 0);
    run0(1'b0, 16'h0, 0, 1'b0);

    run1(-1);
    run1(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_vector_checker.md
IO_VECTOR_CHECKER -- requirements
Module: io_vector_checker

Interface
REQ-001 Parameter NUM_IN, default 2: width of the stimulus bus driven to the fabric pads; legal range 1..16.
REQ-002 Parameter NUM_OUT, default 1: width of the observed DUT response bus; legal range 1..32.
REQ-003 Parameter SETTLE_CYCLES, default 5: cycles each vector is held before its response is sampled; legal range 1..255.
REQ-004 Parameter CNT_W, default 16: width of the vector-count, vector-index and fail counters.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 global_resetn  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  single-cycle run request; honoured only in IDLE or DONE.
REQ-008 abort  input  1  stops a run in progress.
REQ-009 mode  input  1  0 = exhaustive count, 1 = LFSR random.
REQ-010 seed  input  16  LFSR seed, sampled on start.
REQ-011 vec_count  input  CNT_W  number of vectors in random mode, sampled on start.
REQ-012 dut_in  output  NUM_IN  registered stimulus to the DUT pads.
REQ-013 dut_out  input  NUM_OUT  DUT response.
REQ-014 exp_out  input  NUM_OUT  expected response from the external golden model, which is combinational on dut_in.
REQ-015 busy  output  1  high in SETTLE and CHECK.
REQ-016 done  output  1  high in DONE.
REQ-017 pass  output  1  high in DONE when fail_count is 0.
REQ-018 fail_count  output  CNT_W  mismatching vectors; saturates at all-ones.
REQ-019 first_fail_idx  output  CNT_W  index of the first mismatching vector; all-ones if none.
REQ-020 vec_idx  output  CNT_W  index of the vector currently applied.

Function
REQ-021 The FSM SHALL have the states IDLE, SETTLE, CHECK and DONE.
REQ-022 IDLE/DONE + start: state -> SETTLE; vec_idx, fail_count and settle counter cleared; first_fail_idx set to all-ones; dut_in loaded with vector 0.
REQ-023 Vector 0 SHALL be 0 in exhaustive mode, and lfsr[NUM_IN-1:0] after the seed load in random mode.
REQ-024 Random mode SHALL use a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, shifting right once per vector; seed 0 SHALL be replaced by 16'hACE1.
REQ-025 Exhaustive mode SHALL apply vectors 0..2^NUM_IN-1 in ascending order, with vector value equal to vec_idx; vec_count SHALL be ignored.
REQ-026 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-027 CHECK SHALL last 1 cycle: if dut_out != exp_out (bitwise), fail_count increments (saturating), and first_fail_idx <= vec_idx if it is still all-ones.
REQ-028 CHECK on the last vector SHALL go to DONE; otherwise vec_idx increments, dut_in advances to the next vector, and state -> SETTLE.
REQ-029 Per-vector time SHALL be SETTLE_CYCLES+1 cycles; done rises (SETTLE_CYCLES+1)*N cycles after the start edge.
REQ-030 Random mode with vec_count == 0 SHALL go IDLE -> DONE directly with pass = 1 and fail_count = 0.
REQ-031 start while busy SHALL be ignored.
REQ-032 abort in SETTLE or CHECK SHALL return to IDLE at the next edge with no compare that cycle; counters hold and done stays low.
REQ-033 abort and start in the same cycle: abort wins.
REQ-034 DONE SHALL hold dut_in, counters and pass until the next start.

Reset
REQ-035 global_resetn low SHALL immediately set state = IDLE and dut_in, busy, done, pass, fail_count, vec_idx = 0, first_fail_idx = all-ones, and lfsr = 16'hACE1, including mid-run.
REQ-036 After release, the block SHALL be idle until the first start.

Verification
REQ-037 Default parameters, golden = AND, DUT = AND, exhaustive -> dut_in 0,1,2,3; done 24 cycles after start; pass=1, fail_count=0, first_fail_idx=16'hFFFF.
REQ-038 Same setup with DUT = OR -> fail_count=2, first_fail_idx=1, pass=0.
REQ-039 Random mode, seed=0, vec_count=7 -> LFSR starts at 16'hACE1; dut_in matches the reference LFSR sequence; done after 42 cycles.
REQ-040 Random mode, vec_count=0 -> done 1 cycle after start, pass=1.
REQ-041 Reset asserted at vector 2, then released and start issued -> all outputs at reset values immediately; rerun result identical to REQ-037.
REQ-042 CNT_W=2, NUM_IN=3, DUT output stuck-at-1, golden = AND -> fail_count saturates at 3; start while busy and abort mid-SETTLE behave per REQ-031 and REQ-032.
